// File: rtl/dac_burst_shaper_if.sv
// Sample bus between the PSK modulator and the DAC burst shaper.
// master: modulator side (drives DAC_* and BYPASS, observes the DAC pins).
// slave : shaper side (consumes DAC_* and BYPASS, drives OUT_*, PA_EN, RAMP_STATE, BURST_SHORT).
//   DAC_I/DAC_Q   12b two's-complement samples
//   DAC_valid     high for the whole burst
//   DAC_bits      symbol bits tagged to the sample
//   BYPASS        force unity gain
//   OUT_I/OUT_Q   12b offset-binary samples to the DAC
//   OUT_valid     delayed sample valid
//   OUT_bits      delayed symbol bits
//   PA_EN         power-amplifier enable
//   RAMP_STATE    envelope state (0 idle, 1 up, 2 steady, 3 down)
//   BURST_SHORT   one-cycle pulse at the end of a too-short burst
interface dac_burst_shaper_if;
    logic [11:0] DAC_I;
    logic [11:0] DAC_Q;
    logic        DAC_valid;
    logic [1:0]  DAC_bits;
    logic        BYPASS;
    logic [11:0] OUT_I;
    logic [11:0] OUT_Q;
    logic        OUT_valid;
    logic [1:0]  OUT_bits;
    logic        PA_EN;
    logic [1:0]  RAMP_STATE;
    logic        BURST_SHORT;

    modport master (
        output DAC_I, DAC_Q, DAC_valid, DAC_bits, BYPASS,
        input  OUT_I, OUT_Q, OUT_valid, OUT_bits, PA_EN, RAMP_STATE, BURST_SHORT
    );

    modport slave (
        input  DAC_I, DAC_Q, DAC_valid, DAC_bits, BYPASS,
        output OUT_I, OUT_Q, OUT_valid, OUT_bits, PA_EN, RAMP_STATE, BURST_SHORT
    );
endinterface

// File: rtl/dac_burst_shaper.sv
// DAC burst shaper: delays each burst by RAMP_LEN samples, applies a linear
// amplitude ramp-up/ramp-down envelope, converts to offset binary, parks the
// DAC at midscale between bursts and frames the burst with PA_EN.
// Ports:
//   clk_16M384  sample clock
//   rst_16M384  asynchronous active-high reset
//   bus         dac_burst_shaper_if.slave (DAC_* in, OUT_*/PA_EN/RAMP_STATE/BURST_SHORT out)
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | no burst in the delay line, DAC parked at midscale
// RAMP_UP   | gain climbing toward RAMP_LEN
// STEADY    | gain at RAMP_LEN
// RAMP_DOWN | input ended, gain falling toward zero
module dac_burst_shaper #(
    parameter int RAMP_LEN  = 16,
    parameter int RAMP_LOG2 = 4,
    parameter int PA_LEAD   = 4
) (
    input  logic              clk_16M384,
    input  logic              rst_16M384,
    dac_burst_shaper_if.slave bus
);
    localparam int GW     = RAMP_LOG2 + 1;
    localparam int PW     = 12 + GW + 1;
    localparam int RW     = $clog2(RAMP_LEN + 2);
    localparam int PA_DLY = RAMP_LEN - PA_LEAD;
    localparam int CW     = $clog2(PA_DLY + 1);
    localparam logic [GW-1:0] G_MAX   = GW'(RAMP_LEN);
    localparam logic [RW-1:0] RUN_MAX = RW'(RAMP_LEN);
    localparam logic [RW-1:0] RUN_SAT = RW'(RAMP_LEN + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        STEADY    = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    logic [11:0] dl_i [RAMP_LEN];
    logic [11:0] dl_q [RAMP_LEN];
    logic [1:0]  dl_b [RAMP_LEN];
    logic        dl_v [RAMP_LEN];

    logic        head_v;
    logic [11:0] tail_i;
    logic [11:0] tail_q;
    logic [1:0]  tail_b;
    logic        tail_v;

    logic [GW-1:0] g;
    logic [GW-1:0] g_eff;
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] samp_i_ext;
    logic signed [PW-1:0] samp_q_ext;
    logic signed [PW-1:0] prod_i;
    logic signed [PW-1:0] prod_q;
    logic [11:0] s_i;
    logic [11:0] s_q;

    state_t state;
    state_t state_next;
    logic   idle_entry;

    logic [RW-1:0] tail_run;
    logic [CW-1:0] pa_cnt;
    logic          pa_accept;
    logic          pa_fire;

    assign head_v = bus.DAC_valid;
    assign tail_i = dl_i[RAMP_LEN-1];
    assign tail_q = dl_q[RAMP_LEN-1];
    assign tail_b = dl_b[RAMP_LEN-1];
    assign tail_v = dl_v[RAMP_LEN-1];

    always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
        if (rst_16M384) begin
            for (int k = 0; k < RAMP_LEN; k++) begin
                dl_i[k] <= '0;
                dl_q[k] <= '0;
                dl_b[k] <= '0;
                dl_v[k] <= 1'b0;
            end
        end else begin
            dl_i[0] <= bus.DAC_I;
            dl_q[0] <= bus.DAC_Q;
            dl_b[0] <= bus.DAC_bits;
            dl_v[0] <= bus.DAC_valid;
            for (int k = 1; k < RAMP_LEN; k++) begin
                dl_i[k] <= dl_i[k-1];
                dl_q[k] <= dl_q[k-1];
                dl_b[k] <= dl_b[k-1];
                dl_v[k] <= dl_v[k-1];
            end
        end
    end

    always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
        if (rst_16M384) begin
            g <= '0;
        end else if (head_v && tail_v && g != G_MAX) begin
            g <= g + GW'(1);
        end else if (!head_v && g != '0) begin
            g <= g - GW'(1);
        end
    end

    // Gain is zero-extended before the signed multiply so g == RAMP_LEN
    // is not read as a negative value.
    always_comb begin
        g_eff      = bus.BYPASS ? G_MAX : g;
        gain_ext   = PW'({1'b0, g_eff});
        samp_i_ext = PW'($signed(tail_i));
        samp_q_ext = PW'($signed(tail_q));
        prod_i     = samp_i_ext * gain_ext;
        prod_q     = samp_q_ext * gain_ext;
        s_i        = 12'(prod_i >>> RAMP_LOG2);
        s_q        = 12'(prod_q >>> RAMP_LOG2);
    end

    always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
        if (rst_16M384) begin
            bus.OUT_I     <= 12'h800;
            bus.OUT_Q     <= 12'h800;
            bus.OUT_valid <= 1'b0;
            bus.OUT_bits  <= '0;
        end else begin
            bus.OUT_I     <= tail_v ? {~s_i[11], s_i[10:0]} : 12'h800;
            bus.OUT_Q     <= tail_v ? {~s_q[11], s_q[10:0]} : 12'h800;
            bus.OUT_valid <= tail_v;
            bus.OUT_bits  <= tail_b;
        end
    end

    // The tail run length equals the burst length; checked when tail valid falls.
    always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
        if (rst_16M384) begin
            tail_run        <= '0;
            bus.BURST_SHORT <= 1'b0;
        end else if (tail_v) begin
            if (tail_run != RUN_SAT) begin
                tail_run <= tail_run + RW'(1);
            end
            bus.BURST_SHORT <= 1'b0;
        end else begin
            bus.BURST_SHORT <= (tail_run != '0) && (tail_run <= RUN_MAX);
            tail_run        <= '0;
        end
    end

    always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
        if (rst_16M384) begin
            state      <= IDLE;
            idle_entry <= 1'b0;
        end else begin
            state      <= state_next;
            idle_entry <= (state != IDLE) && (state_next == IDLE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (tail_v) state_next = RAMP_UP;
            end
            RAMP_UP: begin
                if (!head_v)         state_next = RAMP_DOWN;
                else if (g == G_MAX) state_next = STEADY;
            end
            STEADY: begin
                if (!head_v) state_next = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (head_v)                      state_next = RAMP_UP;
                else if (g == '0 && !tail_v)     state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.RAMP_STATE = state;

    // A rising head valid arms the PA timer. A rise in the same cycle that
    // PA_EN is being dropped still arms it, so a burst that starts right as
    // the previous one finishes is not left without a PA strobe.
    assign pa_accept = head_v && !dl_v[0] && (!bus.PA_EN || idle_entry);
    assign pa_fire   = pa_accept ? (PA_DLY == 1) : (pa_cnt == CW'(1));

    always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
        if (rst_16M384) begin
            pa_cnt     <= '0;
            bus.PA_EN  <= 1'b0;
        end else begin
            if (pa_accept) begin
                pa_cnt <= CW'(PA_DLY - 1);
            end else if (pa_cnt != '0) begin
                pa_cnt <= pa_cnt - CW'(1);
            end
            if (pa_fire) begin
                bus.PA_EN <= 1'b1;
            end else if (idle_entry) begin
                bus.PA_EN <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dac_burst_shaper.sv
module tb_dac_burst_shaper;
    localparam int RL   = 16;
    localparam int RLOG = 4;
    localparam int PL   = 4;
    localparam int MAXC = 8192;

    logic clk_16M384 = 1'b0;
    logic rst_16M384 = 1'b1;

    dac_burst_shaper_if bus();

    dac_burst_shaper #(.RAMP_LEN(RL), .RAMP_LOG2(RLOG), .PA_LEAD(PL)) dut (
        .clk_16M384 (clk_16M384),
        .rst_16M384 (rst_16M384),
        .bus        (bus.slave)
    );

    always #5 clk_16M384 = ~clk_16M384;

    // Input history and reference-model trajectories, indexed by cycle since reset.
    bit hv[MAXC];
    int hi[MAXC];
    int hq[MAXC];
    int hb[MAXC];
    bit hbyp[MAXC];
    int gm[MAXC+1];
    int stm[MAXC+1];
    bit pam[MAXC+1];
    int pa_at;

    int o_i[MAXC];
    int o_q[MAXC];
    bit o_v[MAXC];
    bit o_pa[MAXC];
    bit o_bs[MAXC];
    int o_st[MAXC];

    int t;
    int n_tests;
    int n_fail;

    function automatic bit tv(int c);
        return (c >= RL) ? hv[c-RL] : 1'b0;
    endfunction

    // floor(x*g/RL) done with plain integer arithmetic
    function automatic int shaped(int x, int g);
        int p;
        int r;
        p = x * g;
        r = ((p % RL) + RL) % RL;
        return (p - r) / RL;
    endfunction

    function automatic int offs(int s);
        return (s + 2048) & 'hFFF;
    endfunction

    function automatic int run_end(int c);
        int n;
        n = 0;
        while (n <= RL && c - n >= 0 && tv(c - n)) n++;
        return n;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < MAXC; k++) begin
            hv[k] = 1'b0;
            hb[k] = 0;
        end
        t      = 0;
        gm[0]  = 0;
        stm[0] = 0;
        pam[0] = 1'b0;
        pa_at  = -1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_out_i"}, int'(bus.OUT_I), 'h800);
        check({pfx, "_out_q"}, int'(bus.OUT_Q), 'h800);
        check({pfx, "_out_valid"}, int'(bus.OUT_valid), 0);
        check({pfx, "_pa_en"}, int'(bus.PA_EN), 0);
        check({pfx, "_state"}, int'(bus.RAMP_STATE), 0);
        check({pfx, "_burst_short"}, int'(bus.BURST_SHORT), 0);
    endtask

    task automatic hold_reset();
        bus.DAC_valid = 1'b0;
        bus.DAC_I     = '0;
        bus.DAC_Q     = '0;
        bus.DAC_bits  = '0;
        bus.BYPASS    = 1'b0;
        rst_16M384    = 1'b1;
        repeat (3) @(posedge clk_16M384);
        #1;
        check_reset_outputs("reset");
        rst_16M384 = 1'b0;
        model_clear();
    endtask

    task automatic do_cycle(input bit v, input int si, input int sq, input bit byp);
        int c;
        int ev;
        int ei;
        int eq;
        int eb;
        int ebs;
        int g;
        int ns;
        bit tvt;
        bit idle_entry;
        bit rise;
        if (t >= MAXC - 2) begin
            n_fail++;
            $display("FAIL cycle_budget: observed %0d cycles, limit %0d", t, MAXC - 2);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $fatal(1, "cycle budget exhausted");
        end
        hv[t]   = v;
        hi[t]   = si;
        hq[t]   = sq;
        hb[t]   = int'($urandom_range(0, 3));
        hbyp[t] = byp;
        bus.DAC_valid = v;
        bus.DAC_I     = 12'(si);
        bus.DAC_Q     = 12'(sq);
        bus.DAC_bits  = 2'(hb[t]);
        bus.BYPASS    = byp;

        @(negedge clk_16M384);
        c  = t - 1;
        ev = (c >= 0) ? int'(tv(c)) : 0;
        if (ev != 0) begin
            g  = hbyp[c] ? RL : gm[c];
            ei = offs(shaped(hi[c-RL], g));
            eq = offs(shaped(hq[c-RL], g));
        end else begin
            ei = 'h800;
            eq = 'h800;
        end
        eb  = (c >= RL) ? hb[c-RL] : 0;
        ebs = (c >= 1 && !tv(c) && tv(c-1) && run_end(c-1) <= RL) ? 1 : 0;
        check("out_valid", int'(bus.OUT_valid), ev);
        check("out_i", int'(bus.OUT_I), ei);
        check("out_q", int'(bus.OUT_Q), eq);
        check("out_bits", int'(bus.OUT_bits), eb);
        check("ramp_state", int'(bus.RAMP_STATE), stm[t]);
        check("pa_en", int'(bus.PA_EN), int'(pam[t]));
        check("burst_short", int'(bus.BURST_SHORT), ebs);
        o_i[t]  = int'(bus.OUT_I);
        o_q[t]  = int'(bus.OUT_Q);
        o_v[t]  = bus.OUT_valid;
        o_pa[t] = bus.PA_EN;
        o_bs[t] = bus.BURST_SHORT;
        o_st[t] = int'(bus.RAMP_STATE);

        // envelope rules
        tvt = tv(t);
        g   = gm[t];
        if (hv[t] && tvt && g < RL)  g = g + 1;
        else if (!hv[t] && g > 0)    g = g - 1;
        gm[t+1] = g;
        case (stm[t])
            0:       ns = tvt ? 1 : 0;
            1:       ns = !hv[t] ? 3 : ((gm[t] == RL) ? 2 : 1);
            2:       ns = !hv[t] ? 3 : 2;
            default: ns = hv[t] ? 1 : ((gm[t] == 0 && !tvt) ? 0 : 3);
        endcase
        stm[t+1] = ns;
        idle_entry = (t > 0) && stm[t] == 0 && stm[t-1] != 0;
        rise       = hv[t] && (t == 0 || !hv[t-1]);
        if (rise && (!pam[t] || idle_entry)) pa_at = t + RL - PL;
        if (pa_at == t + 1)  pam[t+1] = 1'b1;
        else if (idle_entry) pam[t+1] = 1'b0;
        else                 pam[t+1] = pam[t];

        @(posedge clk_16M384);
        #1;
        t++;
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic burst(input int len, input int gap, input bit byp,
                         input bit fixed, input int fi, input int fq);
        for (int k = 0; k < len; k++) begin
            if (fixed) do_cycle(1'b1, fi, fq, byp);
            else       do_cycle(1'b1, rnd_sample(), rnd_sample(), byp);
        end
        for (int k = 0; k < gap; k++) do_cycle(1'b0, rnd_sample(), rnd_sample(), byp);
    endtask

    initial begin
        int t0;
        int c;
        int cnt;
        int mx;
        int step;
        bit found;
        n_tests = 0;
        n_fail  = 0;

        // reset
        hold_reset();
        do_cycle(1'b0, 0, 0, 1'b0);
        do_cycle(1'b0, 0, 0, 1'b0);

        // full trapezoid, 64 samples
        t0 = t;
        burst(64, 40, 1'b0, 1'b1, 2047, -2048);
        c = t0;
        while (c < t && !o_v[c]) c++;
        check("t2_latency", c - t0, 17);
        check("t2_first_i", o_i[t0+17], 'h800);
        check("t2_second_i", o_i[t0+18], 'h87F);
        check("t2_third_i", o_i[t0+19], 'h8FF);
        c = t0;
        while (c < t && o_st[c] != 2) c++;
        check("t2_steady_i", (c < t) ? o_i[c] : -1, 'hFFF);
        check("t2_steady_q", (c < t) ? o_q[c] : -1, 'h000);
        check("t2_last_i", o_i[t0+80], 'h87F);
        check("t2_last_q", o_q[t0+80], 'h780);
        check("t2_after_valid", int'(o_v[t0+81]), 0);
        check("t2_pa_before", int'(o_pa[t0+11]), 0);
        check("t2_pa_rise", int'(o_pa[t0+12]), 1);
        c = t0 + 18;
        while (c < t - 1 && o_st[c] != 0) c++;
        check("t2_pa_at_idle", int'(o_pa[c]), 1);
        check("t2_pa_after_idle", int'(o_pa[c+1]), 0);

        // triangular, 24 samples
        t0 = t;
        burst(24, 40, 1'b0, 1'b1, 2047, -2048);
        mx = 0;
        cnt = 0;
        for (int k = t0; k < t; k++) begin
            if (o_i[k] > mx) mx = o_i[k];
            if (o_bs[k]) cnt++;
        end
        check("t3_peak_i", mx, 'hBFF);
        check("t3_burst_short", cnt, 0);

        // short burst, 10 samples
        t0 = t;
        burst(10, 40, 1'b0, 1'b1, 2047, -2048);
        cnt = 0;
        mx = 0;
        step = 0;
        for (int k = t0; k < t; k++) begin
            if (o_v[k]) cnt++;
            if (o_i[k] != 'h800 || o_q[k] != 'h800) mx++;
            if (o_bs[k]) step++;
        end
        check("t4_valid_cycles", cnt, 10);
        check("t4_non_midscale", mx, 0);
        check("t4_short_pulses", step, 1);

        // merged bursts, 5-cycle gap
        t0 = t;
        burst(40, 5, 1'b0, 1'b1, 2047, -2048);
        burst(40, 40, 1'b0, 1'b1, 2047, -2048);
        mx = 0;
        found = 1'b0;
        for (int k = t0 + 1; k < t; k++) begin
            if (o_v[k] && o_v[k-1]) begin
                step = o_i[k] - o_i[k-1];
                if (step < 0) step = -step;
                if (step > mx) mx = step;
            end
            if (o_st[k-1] == 3 && o_st[k] == 1) found = 1'b1;
        end
        check("t5_max_step_ok", int'(mx <= 128), 1);
        check("t5_down_to_up", int'(found), 1);

        // bypass burst interrupted by asynchronous reset at sample 20
        t0 = t;
        for (int k = 0; k < 20; k++) do_cycle(1'b1, rnd_sample(), rnd_sample(), 1'b1);
        check("t6_latency_valid", int'(o_v[t0+17]), 1);
        check("t6_unity_i", o_i[t0+17], offs(hi[t0]));
        check("t6_unity_q", o_q[t0+17], offs(hq[t0]));
        #1;
        rst_16M384 = 1'b1;
        #1;
        check_reset_outputs("async");
        hold_reset();
        t0 = t;
        burst(40, 40, 1'b1, 1'b0, 0, 0);
        check("t6b_start_state", o_st[t0], 0);
        check("t6b_pre_valid", int'(o_v[t0+16]), 0);
        check("t6b_latency_valid", int'(o_v[t0+17]), 1);
        check("t6b_unity_i", o_i[t0+17], offs(hi[t0]));

        // randomized bursts
        for (int n = 0; n < 16; n++) begin
            burst(int'($urandom_range(1, 50)), int'($urandom_range(1, 30)),
                  1'($urandom_range(0, 1)), 1'b0, 0, 0);
        end
        burst(0, 45, 1'b0, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
